// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave port and its helpers.
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Mode encoding is {cpol, cpha}.
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/spi_sclk_edge_det.sv
// SCLK edge classifier: one registered copy of sclk, with the leading/trailing
// decision made against the idle polarity latched while disarmed.
module spi_sclk_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cpol,
  input  logic arm,
  output logic lead_pulse,
  output logic trail_pulse
);

  logic sclk_q, sclk_d;
  logic cpol_q, cpol_d;
  logic edge_seen;

  // While disarmed, park the sclk copy at idle level so the first real edge is seen.
  always_comb begin
    sclk_d = arm ? sclk : cpol;
    cpol_d = arm ? cpol_q : cpol;
  end

  // Registered sclk copy and latched polarity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 1'b0;
      cpol_q <= 1'b0;
    end else begin
      sclk_q <= sclk_d;
      cpol_q <= cpol_d;
    end
  end

  // An edge leaving the idle level is leading; returning to it is trailing.
  always_comb begin
    edge_seen   = arm && (sclk != sclk_q);
    lead_pulse  = edge_seen && (sclk_q == cpol_q);
    trail_pulse = edge_seen && (sclk_q != cpol_q);
  end

endmodule

// File: rtl/spi_slave_port.sv
// SPI slave endpoint, LSB-first, all four CPOL/CPHA modes, with a one-deep TX
// holding register and an RX result register behind a valid/ack handshake.
module spi_slave_port
  import spi_pkg::*;
#(
  parameter int   DATA_W    = DATA_W_DEF,
  parameter logic CS_ACTIVE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              overrun,
  output logic              frame_abort,
  output logic              busy
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] shift_tx_q, shift_tx_d;
  logic [DATA_W-1:0] shift_rx_q, shift_rx_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              tx_ready_q, tx_ready_d;
  logic              rx_valid_q, rx_valid_d;
  logic              overrun_q, overrun_d;
  logic              abort_q, abort_d;
  logic              first_q, first_d;

  logic cs_on, lead_pulse, trail_pulse, sample_lead;
  logic samp_pulse, shift_pulse, consume;

  assign cs_on       = (cs == CS_ACTIVE);
  assign sample_lead = (mode_q == MODE0) || (mode_q == MODE2);
  assign samp_pulse  = sample_lead ? lead_pulse : trail_pulse;
  assign shift_pulse = sample_lead ? trail_pulse : lead_pulse;

  spi_sclk_edge_det u_edge (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk        (sclk),
    .cpol        (cpol),
    .arm         (state_q == SHIFT),
    .lead_pulse  (lead_pulse),
    .trail_pulse (trail_pulse)
  );

  // State register plus all datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= MODE0;
      hold_q     <= '0;
      shift_tx_q <= '0;
      shift_rx_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      tx_ready_q <= 1'b1;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      abort_q    <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      hold_q     <= hold_d;
      shift_tx_q <= shift_tx_d;
      shift_rx_q <= shift_rx_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      abort_q    <= abort_d;
      first_q    <= first_d;
    end
  end

  // Next state: enter on select, drop back whenever select is released.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_on)  state_d = SHIFT;
      SHIFT:   if (!cs_on) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift, count, frame completion and TX/RX handshake bookkeeping.
  always_comb begin
    mode_d     = mode_q;
    hold_d     = hold_q;
    shift_tx_d = shift_tx_q;
    shift_rx_d = shift_rx_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    tx_ready_d = tx_ready_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    abort_d    = 1'b0;
    first_d    = first_q;
    consume    = 1'b0;

    if (rx_ack) rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        mode_d    = {cpol, cpha};
        bit_cnt_d = '0;
        if (cs_on) begin
          consume    = 1'b1;
          shift_tx_d = tx_ready_q ? '0 : hold_q;
          first_d    = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == CNT_FULL) begin
          // Completion: an ack landing now frees the slot, so no overrun.
          bit_cnt_d = '0;
          if (!rx_valid_q || rx_ack) begin
            rx_data_d  = shift_rx_q;
            rx_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
          if (cs_on) begin
            consume    = 1'b1;
            shift_tx_d = tx_ready_q ? '0 : hold_q;
            // A next-frame leading edge arriving now is that frame's no-shift edge.
            first_d    = !shift_pulse;
          end
        end else if (!cs_on) begin
          abort_d = (bit_cnt_q != '0);
        end else begin
          if (shift_pulse) begin
            if (sample_lead || !first_q) shift_tx_d = shift_tx_q >> 1;
            first_d = 1'b0;
          end
          if (samp_pulse) begin
            shift_rx_d = {mosi, shift_rx_q[DATA_W-1:1]};
            bit_cnt_d  = bit_cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Frame-start copy empties the holding reg before a same-cycle load lands.
    if (consume) tx_ready_d = 1'b1;
    if (tx_load && (tx_ready_q || consume)) begin
      hold_d     = tx_data;
      tx_ready_d = 1'b0;
    end
  end

  // Outputs: bit0 is presented straight from the shift register.
  always_comb begin
    miso        = (state_q == SHIFT) ? shift_tx_q[0] : 1'b0;
    busy        = (state_q == SHIFT);
    tx_ready    = tx_ready_q;
    rx_data     = rx_data_q;
    rx_valid    = rx_valid_q;
    overrun     = overrun_q;
    frame_abort = abort_q;
  end

endmodule
